// File: rtl/awgn_cmplx_adder.sv
// Complex AWGN injection: paces the noise generator, buffers its samples,
// scales them by a programmable gain and adds them to the I/Q signal with saturation.
`timescale 1ns/1ps
module awgn_cmplx_adder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] GAIN_INIT  = 16'd8192
) (
    input  logic               clk,
    input  logic               rst,
    output logic               noise_ce,
    input  logic               noise_valid,
    input  logic signed [15:0] noise_re,
    input  logic signed [15:0] noise_im,
    input  logic               sig_valid,
    input  logic signed [15:0] sig_re,
    input  logic signed [15:0] sig_im,
    input  logic [15:0]        gain_in,
    input  logic               gain_load,
    input  logic               noise_en,
    input  logic               cnt_clr,
    output logic               out_valid,
    output logic signed [15:0] out_re,
    output logic signed [15:0] out_im,
    output logic [15:0]        sat_cnt,
    output logic [15:0]        udr_cnt,
    output logic               ovf
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // (p + 2^14) >>> 15, round half up; result always fits 17 bits
    function automatic logic signed [DATA_W:0] round_scale(input logic signed [31:0] p);
        logic signed [31:0] t;
        t = p + 32'sd16384;
        return 17'(t >>> 15);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_s16(input logic signed [DATA_W+1:0] s);
        if (s > 18'sd32767)
            return 16'sh7FFF;
        else if (s < -18'sd32768)
            return 16'sh8000;
        else
            return s[DATA_W-1:0];
    endfunction

    function automatic logic clips(input logic signed [DATA_W+1:0] s);
        return (s > 18'sd32767) || (s < -18'sd32768);
    endfunction

    logic signed [DATA_W-1:0] fifo_re [FIFO_DEPTH];
    logic signed [DATA_W-1:0] fifo_im [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic [CW-1:0]            reserved, reserved_next;
    logic                     fifo_empty, fifo_full, push_do, pop_do, underrun;
    logic [COEF_W-1:0]        gain;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == DEPTH_C);
        push_do    = noise_valid && !fifo_full;
        pop_do     = sig_valid && !fifo_empty;
        underrun   = sig_valid && fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_do)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_do)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_do && !pop_do)
                count <= count + 1'b1;
            else if (pop_do && !push_do)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_do) begin
            fifo_re[wr_ptr] <= noise_re;
            fifo_im[wr_ptr] <= noise_im;
        end
    end

    // reserved tracks buffered plus requested-but-not-yet-delivered samples
    always_comb begin
        reserved_next = reserved;
        if (noise_ce && !pop_do)
            reserved_next = reserved + 1'b1;
        else if (!noise_ce && pop_do && reserved != '0)
            reserved_next = reserved - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reserved <= '0;
            noise_ce <= 1'b0;
            ovf      <= 1'b0;
            gain     <= GAIN_INIT;
        end else begin
            reserved <= reserved_next;
            noise_ce <= (reserved_next < DEPTH_C);
            if (noise_valid && fifo_full)
                ovf <= 1'b1;
            if (gain_load)
                gain <= gain_in;
        end
    end

    // ---- S1: capture signal, popped noise and the gain in force at sig_valid
    logic                     vld_p1;
    logic signed [DATA_W-1:0] sig_re_p1, sig_im_p1, nz_re_p1, nz_im_p1;
    logic signed [DATA_W-1:0] nz_re_sel, nz_im_sel;
    logic [COEF_W-1:0]        gain_p1;

    always_comb begin
        nz_re_sel = '0;
        nz_im_sel = '0;
        if (pop_do && noise_en) begin
            nz_re_sel = fifo_re[rd_ptr];
            nz_im_sel = fifo_im[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= sig_valid;
    end

    always_ff @(posedge clk) begin
        sig_re_p1 <= sig_re;
        sig_im_p1 <= sig_im;
        nz_re_p1  <= nz_re_sel;
        nz_im_p1  <= nz_im_sel;
        gain_p1   <= gain;
    end

    // ---- S2: noise x gain, rounded back to the s<16,11> grid
    logic                     vld_p2;
    logic signed [DATA_W-1:0] sig_re_p2, sig_im_p2;
    logic signed [DATA_W:0]   sc_re_p2, sc_im_p2;
    logic signed [31:0]       prod_re, prod_im;

    always_comb begin
        prod_re = 32'(nz_re_p1) * 32'($signed({1'b0, gain_p1}));
        prod_im = 32'(nz_im_p1) * 32'($signed({1'b0, gain_p1}));
    end

    always_ff @(posedge clk) begin
        if (rst)
            vld_p2 <= 1'b0;
        else
            vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) begin
        sig_re_p2 <= sig_re_p1;
        sig_im_p2 <= sig_im_p1;
        sc_re_p2  <= round_scale(prod_re);
        sc_im_p2  <= round_scale(prod_im);
    end

    // ---- S3: add, saturate, count clipped samples
    logic signed [DATA_W+1:0] sum_re, sum_im;
    logic                     clip_any;

    always_comb begin
        sum_re   = 18'(sig_re_p2) + 18'(sc_re_p2);
        sum_im   = 18'(sig_im_p2) + 18'(sc_im_p2);
        clip_any = clips(sum_re) || clips(sum_im);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            sat_cnt   <= '0;
            udr_cnt   <= '0;
        end else begin
            out_valid <= vld_p2;
            if (vld_p2) begin
                out_re <= sat_s16(sum_re);
                out_im <= sat_s16(sum_im);
            end
            if (cnt_clr)
                sat_cnt <= '0;
            else if (vld_p2 && clip_any && sat_cnt != 16'hFFFF)
                sat_cnt <= sat_cnt + 1'b1;
            if (cnt_clr)
                udr_cnt <= '0;
            else if (underrun && udr_cnt != 16'hFFFF)
                udr_cnt <= udr_cnt + 1'b1;
        end
    end

endmodule
